// File: rtl/piton_core_wake_if.sv
// rtl/piton_core_wake_if.sv - L1.5 interrupt packet handshake bundle
interface piton_core_wake_if;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [1:0] pkt_type;
    logic [7:0] pkt_data;

    modport master (output pkt_valid, pkt_type, pkt_data, input pkt_ready);
    modport slave  (input pkt_valid, pkt_type, pkt_data, output pkt_ready);
endinterface

// File: rtl/piton_core_wake_ctrl.sv
// rtl/piton_core_wake_ctrl.sv - core bring-up, IPI and debug-request sequencer (option: PITON_CORE_AUTOWAKE_EN)
module piton_core_wake_ctrl #(
    parameter int unsigned InitCycles = 32768,
    parameter int unsigned HoldCycles = 16
) (
    input  logic                clk_i,
    input  logic                reset_l,
    piton_core_wake_if.slave    pkt,
    output logic                core_rst_no,
    output logic                ipi_o,
    output logic                debug_req_o,
    output logic [1:0]          state_o
);
    localparam int unsigned MaxCycles = (InitCycles > HoldCycles) ? InitCycles : HoldCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] InitLast = CntW'(InitCycles - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        WAIT_WAKE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam logic [1:0] PKT_RESET   = 2'd0;
    localparam logic [1:0] PKT_IPI_SET = 2'd1;
    localparam logic [1:0] PKT_IPI_CLR = 2'd2;
    localparam logic [1:0] PKT_DEBUG   = 2'd3;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            core_rst_q, core_rst_d;
    logic            ipi_q, ipi_d;
    logic            dbg_q, dbg_d;
    logic            accept;
    logic            arg;
    logic            unused_data;

    assign accept      = pkt.pkt_valid & ready_q;
    assign arg         = pkt.pkt_data[0];
    assign unused_data = ^pkt.pkt_data[7:1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_rst_d = core_rst_q;
        ipi_d      = ipi_q;
        dbg_d      = dbg_q;
        case (state_q)
            INIT: begin
                if (cnt_q == InitLast) begin
                    cnt_d = '0;
`ifdef PITON_CORE_AUTOWAKE_EN
                    state_d = RUN;
`else
                    state_d = WAIT_WAKE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_WAKE: begin
                // Anything other than an explicit wake is consumed and discarded.
                if (accept && pkt.pkt_type == PKT_RESET && !arg) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                core_rst_d = 1'b1;
                if (accept) begin
                    case (pkt.pkt_type)
                        PKT_IPI_SET: ipi_d = 1'b1;
                        PKT_IPI_CLR: ipi_d = 1'b0;
                        PKT_DEBUG:   dbg_d = arg;
                        PKT_RESET: begin
                            if (arg) begin
                                state_d    = HOLD;
                                core_rst_d = 1'b0;
                                ipi_d      = 1'b0;
                                dbg_d      = 1'b0;
                                cnt_d      = '0;
                            end
                        end
                    endcase
                end
            end
            HOLD: begin
                if (cnt_q == HoldLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // Ready is registered alongside the state so it never looks at pkt_valid.
        ready_d = (state_d == WAIT_WAKE) || (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b0;
            ipi_q      <= 1'b0;
            dbg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            core_rst_q <= core_rst_d;
            ipi_q      <= ipi_d;
            dbg_q      <= dbg_d;
        end
    end

    assign pkt.pkt_ready = ready_q;
    assign core_rst_no   = core_rst_q;
    assign ipi_o         = ipi_q;
    assign debug_req_o   = dbg_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_piton_core_wake_ctrl.sv
// tb/tb_piton_core_wake_ctrl.sv - directed vector bench for piton_core_wake_ctrl (InitCycles=8, HoldCycles=4)
module tb_piton_core_wake_ctrl;
    logic       clk_i = 1'b0;
    logic       reset_l = 1'b0;
    logic       core_rst_no;
    logic       ipi_o;
    logic       debug_req_o;
    logic [1:0] state_o;

    piton_core_wake_if pkt ();

    piton_core_wake_ctrl #(
        .InitCycles(8),
        .HoldCycles(4)
    ) dut (
        .clk_i      (clk_i),
        .reset_l    (reset_l),
        .pkt        (pkt),
        .core_rst_no(core_rst_no),
        .ipi_o      (ipi_o),
        .debug_req_o(debug_req_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       v;
        logic [1:0] t;
        logic [7:0] d;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] obs();
        return {pkt.pkt_ready, core_rst_no, ipi_o, debug_req_o, state_o};
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: rdy/rst/ipi/dbg/state got %b want %b", name, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [1:0] t, input logic [7:0] d,
                       input logic rdy, input logic rst, input logic ipi,
                       input logic dbg, input logic [1:0] st);
        vec_t r;
        r.v = v; r.t = t; r.d = d; r.exp = {rdy, rst, ipi, dbg, st};
        vecs.push_back(r);
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] d);
        pkt.pkt_valid = v;
        pkt.pkt_type  = t;
        pkt.pkt_data  = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        drive(1'b0, 2'd0, 8'h00);
        repeat (2) @(negedge clk_i);
        check("reset_values", 6'b0_0_0_0_00);
        reset_l = 1'b1;

`ifdef PITON_CORE_AUTOWAKE_EN
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("auto_init%0d", k), 6'b0_0_0_0_00);
        end
        step();
        check("auto_run_entry", 6'b1_0_0_0_10);
        step();
        check("auto_rst_edge9", 6'b1_1_0_0_10);
        drive(1'b1, 2'd0, 8'h00);
        step();
        check("auto_wake_noop", 6'b1_1_0_0_10);
        drive(1'b1, 2'd0, 8'h01);
        step();
        check("auto_reset_hold", 6'b0_0_0_0_11);
        drive(1'b0, 2'd0, 8'h00);
`else
        // Rows are one clock edge each; expectations are the outputs after that edge.
        for (int k = 1; k <= 4; k++) add(0, 2'd0, 8'h00, 0, 0, 0, 0, 2'd0);
        for (int k = 5; k <= 7; k++) add(1, 2'd1, 8'h01, 0, 0, 0, 0, 2'd0);
        add(1, 2'd1, 8'h01, 1, 0, 0, 0, 2'd1);  // 8: WAIT_WAKE, held packet not yet taken
        add(1, 2'd1, 8'h01, 1, 0, 0, 0, 2'd1);  // 9: IPI_SET accepted, dropped
        add(1, 2'd0, 8'h01, 1, 0, 0, 0, 2'd1);  // 10: RESET(1) dropped
        add(1, 2'd3, 8'h01, 1, 0, 0, 0, 2'd1);  // 11: DEBUG dropped
        add(0, 2'd0, 8'h00, 1, 0, 0, 0, 2'd1);  // 12
        add(1, 2'd0, 8'h00, 1, 0, 0, 0, 2'd2);  // 13: WAKE -> RUN
        add(0, 2'd0, 8'h00, 1, 1, 0, 0, 2'd2);  // 14: core out of reset
        add(1, 2'd1, 8'h00, 1, 1, 1, 0, 2'd2);  // 15: IPI_SET
        add(1, 2'd3, 8'h01, 1, 1, 1, 1, 2'd2);  // 16: DEBUG(1)
        add(1, 2'd2, 8'h00, 1, 1, 0, 1, 2'd2);  // 17: IPI_CLR
        add(1, 2'd2, 8'h00, 1, 1, 0, 1, 2'd2);  // 18: IPI_CLR idempotent
        add(1, 2'd1, 8'h00, 1, 1, 1, 1, 2'd2);  // 19: IPI_SET
        add(1, 2'd1, 8'h00, 1, 1, 1, 1, 2'd2);  // 20: IPI_SET idempotent
        add(1, 2'd0, 8'hFE, 1, 1, 1, 1, 2'd2);  // 21: WAKE in RUN no-op
        add(1, 2'd0, 8'h01, 0, 0, 0, 0, 2'd3);  // 22: RESET(1) -> HOLD
        add(1, 2'd1, 8'h00, 0, 0, 0, 0, 2'd3);  // 23: held IPI_SET ignored
        add(1, 2'd1, 8'h00, 0, 0, 0, 0, 2'd3);  // 24
        add(1, 2'd1, 8'h00, 0, 0, 0, 0, 2'd3);  // 25
        add(1, 2'd1, 8'h00, 1, 0, 0, 0, 2'd2);  // 26: 4 cycles later -> RUN
        add(1, 2'd1, 8'h00, 1, 1, 1, 0, 2'd2);  // 27: held packet taken
        add(1, 2'd3, 8'h01, 1, 1, 1, 1, 2'd2);  // 28: DEBUG(1)
        add(1, 2'd3, 8'h02, 1, 1, 1, 0, 2'd2);  // 29: DEBUG bit0=0
        add(1, 2'd3, 8'h01, 1, 1, 1, 1, 2'd2);  // 30
        add(1, 2'd0, 8'h01, 0, 0, 0, 0, 2'd3);  // 31: RESET from ipi=1,dbg=1
        add(0, 2'd0, 8'h00, 0, 0, 0, 0, 2'd3);  // 32
        add(0, 2'd0, 8'h00, 0, 0, 0, 0, 2'd3);  // 33: mid-HOLD

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].t, vecs[i].d);
            step();
            check($sformatf("row%0d", i + 1), vecs[i].exp);
        end

        #2 reset_l = 1'b0;
        #1 check("async_reset_mid_hold", 6'b0_0_0_0_00);
        @(negedge clk_i);
        check("reset_held", 6'b0_0_0_0_00);
        reset_l = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("reinit%0d", k), 6'b0_0_0_0_00);
        end
        step();
        check("reinit_exit", 6'b1_0_0_0_01);
        repeat (5) step();
        check("no_autowake", 6'b1_0_0_0_01);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
